// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: data-memory access encodings, the zero register
// and the MEM/WB pipeline register layout used by the writeback stage.
package pipeline_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RF_AW = 5;

    // Access size encodings, shared with the data memory and the memory stage.
    typedef enum logic [1:0] {
        DMEM_WORD = 2'b00,
        DMEM_HALF = 2'b01,
        DMEM_BYTE = 2'b10,
        DMEM_RSVD = 2'b11
    } dmem_type_e;

    localparam logic [RF_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic             valid;
        logic [RF_AW-1:0] rd_addr;
        logic             rd_sel;
        logic             rd_we;
        dmem_type_e       dmem_type;
        logic             load_unsigned;
        logic [XLEN-1:0]  alu_result;
        logic [XLEN-1:0]  dmem_data;
    } mem_wb_t;

endpackage

// File: rtl/load_data_extractor.sv
// Combinational load data extraction.
// Ports:
//   word_i          raw aligned word read from data memory
//   dmem_type_i     access size (word / half / byte / reserved = word)
//   load_unsigned_i 1 = zero-extend half/byte results
//   addr_lo_i       low two bits of the byte address (byte lane)
//   data_o          extracted, extended load value
module load_data_extractor
    import pipeline_pkg::*;
(
    input  logic [XLEN-1:0] word_i,
    input  dmem_type_e      dmem_type_i,
    input  logic            load_unsigned_i,
    input  logic [1:0]      addr_lo_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        unique case (addr_lo_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        // addr_lo_i[0] is deliberately ignored: misaligned halves are not trapped.
        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        data_o = word_i;
        unique case (dmem_type_i)
            DMEM_BYTE: data_o = {{24{byte_sel[7] & ~load_unsigned_i}}, byte_sel};
            DMEM_HALF: data_o = {{16{half_sel[15] & ~load_unsigned_i}}, half_sel};
            default:   data_o = word_i;
        endcase
    end

endmodule

// File: rtl/pipeline_writeback_stage.sv
// MEM/WB pipeline register and writeback stage.
// Registers memory-stage outputs (with stall hold and flush bubble), extracts load
// data, selects ALU vs load result and drives the register-file write port. The
// write data doubles as the forwarding tap. Also counts retired valid instructions.
// Ports:
//   clock, reset_n         clock and asynchronous active-low reset
//   stall, flush           hold the register / replace the captured entry with a bubble
//   valid_in .. dmem_data_in  memory-stage outputs captured each unstalled edge
//   wb_valid               registered slot is a real instruction
//   rf_write_enable/address/data  register-file write port
//   retired_count          wrapping count of captured valid instructions
module pipeline_writeback_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = XLEN,
    parameter int unsigned REG_AW     = RF_AW,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  valid_in,
    input  logic [REG_AW-1:0]     rd_write_address_in,
    input  logic                  rd_select_in,
    input  logic                  rd_write_enable_in,
    input  logic [1:0]            dmem_type_in,
    input  logic                  load_unsigned_in,
    input  logic [DATA_WIDTH-1:0] alu_result_in,
    input  logic [DATA_WIDTH-1:0] dmem_data_in,
    output logic                  wb_valid,
    output logic                  rf_write_enable,
    output logic [REG_AW-1:0]     rf_write_address,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    output logic [CNT_WIDTH-1:0]  retired_count
);

    mem_wb_t              entry_d, entry_q;
    logic [CNT_WIDTH-1:0] retired_count_d, retired_count_q;
    logic [XLEN-1:0]      load_data;

    always_comb begin
        entry_d         = entry_q;
        retired_count_d = retired_count_q;
        if (flush) begin
            entry_d = '0;
        end else if (!stall) begin
            entry_d.valid         = valid_in;
            entry_d.rd_addr       = rd_write_address_in;
            entry_d.rd_sel        = rd_select_in;
            entry_d.rd_we         = rd_write_enable_in;
            entry_d.dmem_type     = dmem_type_e'(dmem_type_in);
            entry_d.load_unsigned = load_unsigned_in;
            entry_d.alu_result    = alu_result_in;
            entry_d.dmem_data     = dmem_data_in;
            if (valid_in) begin
                retired_count_d = retired_count_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            entry_q         <= '0;
            retired_count_q <= '0;
        end else begin
            entry_q         <= entry_d;
            retired_count_q <= retired_count_d;
        end
    end

    load_data_extractor u_extract (
        .word_i          (entry_q.dmem_data),
        .dmem_type_i     (entry_q.dmem_type),
        .load_unsigned_i (entry_q.load_unsigned),
        .addr_lo_i       (entry_q.alu_result[1:0]),
        .data_o          (load_data)
    );

    // The strobe drops while stalled so a held entry is written only once.
    assign wb_valid         = entry_q.valid;
    assign rf_write_address = entry_q.rd_addr;
    assign rf_write_enable  = entry_q.valid & entry_q.rd_we & ~stall
                            & (entry_q.rd_addr != REG_ZERO);
    assign rf_write_data    = entry_q.rd_sel ? load_data : entry_q.alu_result;
    assign retired_count    = retired_count_q;

endmodule

// File: tb/tb_pipeline_writeback_stage.sv
module tb_pipeline_writeback_stage;

    logic        clock = 1'b0;
    logic        reset_n, stall, flush, valid_in, rd_sel, rd_we, load_uns;
    logic [4:0]  rd_addr;
    logic [1:0]  dmem_type;
    logic [31:0] alu_in, dmem_in;

    logic        wb_valid, rf_we, wb_valid4, rf_we4;
    logic [4:0]  rf_addr, rf_addr4;
    logic [31:0] rf_data, rf_data4, count;
    logic [3:0]  count4;

    always #5 clock = ~clock;

    pipeline_writeback_stage dut (
        .clock(clock), .reset_n(reset_n), .stall(stall), .flush(flush),
        .valid_in(valid_in), .rd_write_address_in(rd_addr), .rd_select_in(rd_sel),
        .rd_write_enable_in(rd_we), .dmem_type_in(dmem_type), .load_unsigned_in(load_uns),
        .alu_result_in(alu_in), .dmem_data_in(dmem_in),
        .wb_valid(wb_valid), .rf_write_enable(rf_we), .rf_write_address(rf_addr),
        .rf_write_data(rf_data), .retired_count(count)
    );

    pipeline_writeback_stage #(.CNT_WIDTH(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .stall(stall), .flush(flush),
        .valid_in(valid_in), .rd_write_address_in(rd_addr), .rd_select_in(rd_sel),
        .rd_write_enable_in(rd_we), .dmem_type_in(dmem_type), .load_unsigned_in(load_uns),
        .alu_result_in(alu_in), .dmem_data_in(dmem_in),
        .wb_valid(wb_valid4), .rf_write_enable(rf_we4), .rf_write_address(rf_addr4),
        .rf_write_data(rf_data4), .retired_count(count4)
    );

    typedef struct {
        logic        wb_valid;
        logic        rf_we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference model of the registered slot and counters.
    logic        m_v, m_sel, m_we, m_uns;
    logic [4:0]  m_rd;
    logic [1:0]  m_typ;
    logic [31:0] m_alu, m_dm, m_cnt;
    logic [3:0]  m_cnt4;

    function automatic logic [31:0] model_load(input logic [31:0] dm, input logic [1:0] typ,
                                               input logic uns, input logic [1:0] lane);
        logic [31:0] sh;
        if (typ == 2'b10) begin
            sh = dm >> (8 * lane);
            return uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
        end else if (typ == 2'b01) begin
            sh = lane[1] ? (dm >> 16) : dm;
            return uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        end
        return dm;
    endfunction

    task automatic model_clear();
        m_v = 0; m_sel = 0; m_we = 0; m_uns = 0; m_rd = 0; m_typ = 0; m_alu = 0; m_dm = 0;
    endtask

    // Drive one cycle of inputs just after the rising edge and push what the
    // outputs must show before the next edge.
    task automatic apply(input logic rst, input logic stl, input logic fl, input logic v,
                         input logic [4:0] rd, input logic sel, input logic we,
                         input logic [1:0] typ, input logic uns,
                         input logic [31:0] alu, input logic [31:0] dm);
        exp_t e;
        @(posedge clock);
        #1;
        reset_n = rst; stall = stl; flush = fl; valid_in = v; rd_addr = rd; rd_sel = sel;
        rd_we = we; dmem_type = typ; load_uns = uns; alu_in = alu; dmem_in = dm;
        if (!rst) begin
            model_clear();
            m_cnt = 0; m_cnt4 = 0;
        end
        e.wb_valid = m_v;
        e.rf_we    = m_v & m_we & (m_rd != 5'd0) & ~stl;
        e.addr     = m_rd;
        e.data     = m_sel ? model_load(m_dm, m_typ, m_uns, m_alu[1:0]) : m_alu;
        e.cnt      = m_cnt;
        e.cnt4     = m_cnt4;
        q.push_back(e);
        if (rst) begin
            if (fl) begin
                model_clear();
            end else if (!stl) begin
                m_v = v; m_rd = rd; m_sel = sel; m_we = we; m_typ = typ; m_uns = uns;
                m_alu = alu; m_dm = dm;
                if (v) begin
                    m_cnt  = m_cnt + 1;
                    m_cnt4 = m_cnt4 + 4'd1;
                end
            end
        end
    endtask

    task automatic idle();
        apply(1, 0, 0, 0, 5'd0, 0, 0, 2'b00, 0, 32'h0, 32'h0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are checked mid-cycle, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("wb_valid", {31'd0, wb_valid}, {31'd0, e.wb_valid});
                check("rf_write_enable", {31'd0, rf_we}, {31'd0, e.rf_we});
                check("rf_write_address", {27'd0, rf_addr}, {27'd0, e.addr});
                check("rf_write_data", rf_data, e.data);
                check("retired_count", count, e.cnt);
                check("retired_count_w4", {28'd0, count4}, {28'd0, e.cnt4});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    localparam logic [31:0] DM = 32'h80FF_7F01;

    initial begin
        reset_n = 0; stall = 0; flush = 0; valid_in = 0; rd_addr = 0; rd_sel = 0; rd_we = 0;
        dmem_type = 0; load_uns = 0; alu_in = 0; dmem_in = 0;
        model_clear(); m_cnt = 0; m_cnt4 = 0;

        // Reset state
        apply(0, 0, 0, 0, 5'd0, 0, 0, 2'b00, 0, 32'h0, 32'h0);
        apply(0, 0, 0, 1, 5'd3, 0, 1, 2'b00, 0, 32'h1, 32'h0);
        idle();

        // ALU writeback
        apply(1, 0, 0, 1, 5'd5, 0, 1, 2'b00, 0, 32'h1234_5678, 32'hAAAA_5555);
        idle();

        // Load extraction
        apply(1, 0, 0, 1, 5'd6, 1, 1, 2'b10, 0, 32'h0000_1003, DM);  // byte lane 3 signed
        apply(1, 0, 0, 1, 5'd6, 1, 1, 2'b10, 1, 32'h0000_1003, DM);  // byte lane 3 unsigned
        apply(1, 0, 0, 1, 5'd7, 1, 1, 2'b10, 0, 32'h0000_1001, DM);  // byte lane 1 signed
        apply(1, 0, 0, 1, 5'd7, 1, 1, 2'b01, 0, 32'h0000_1000, DM);  // half low signed
        apply(1, 0, 0, 1, 5'd8, 1, 1, 2'b01, 0, 32'h0000_1002, DM);  // half high signed
        apply(1, 0, 0, 1, 5'd8, 1, 1, 2'b01, 1, 32'h0000_1003, DM);  // half high, odd addr, unsigned
        apply(1, 0, 0, 1, 5'd9, 1, 1, 2'b00, 0, 32'h0000_1002, DM);  // word, misaligned
        apply(1, 0, 0, 1, 5'd9, 1, 1, 2'b11, 0, 32'h0000_1001, DM);  // reserved type = word
        apply(1, 0, 0, 1, 5'd10, 1, 0, 2'b10, 0, 32'h0000_1000, DM); // sel=1, we=0: no write

        // $0 destination
        apply(1, 0, 0, 1, 5'd0, 0, 1, 2'b00, 0, 32'hCAFE_F00D, 32'h0);
        idle();

        // Stall hold and flush priority
        apply(1, 0, 0, 1, 5'd11, 0, 1, 2'b00, 0, 32'h0BAD_BEEF, 32'h0);
        apply(1, 1, 0, 1, 5'd12, 0, 1, 2'b00, 0, 32'h1111_1111, 32'h0);
        apply(1, 1, 0, 1, 5'd13, 0, 1, 2'b00, 0, 32'h2222_2222, 32'h0);
        apply(1, 1, 0, 1, 5'd14, 0, 1, 2'b00, 0, 32'h3333_3333, 32'h0);
        apply(1, 1, 1, 1, 5'd15, 0, 1, 2'b00, 0, 32'h4444_4444, 32'h0);
        idle();
        idle();

        // Asynchronous reset while a valid entry is held
        apply(1, 0, 0, 1, 5'd17, 0, 1, 2'b00, 0, 32'hDEAD_BEEF, 32'h0);
        apply(1, 1, 0, 0, 5'd0, 0, 0, 2'b00, 0, 32'h0, 32'h0);
        apply(0, 1, 0, 0, 5'd0, 0, 0, 2'b00, 0, 32'h0, 32'h0);
        idle();

        // Counter wrap on the 4-bit instance: 17 retirements from reset
        for (int i = 0; i < 17; i++) begin
            apply(1, 0, 0, 1, 5'(i + 1), 0, 1, 2'b00, 0, 32'(i * 3), 32'h0);
        end
        idle();
        idle();

        repeat (2) @(posedge clock);
        n_vec++;
        if (q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
